wb_regfile: RTL
===============

# wb_regfile

Dual-write, quad-read architectural integer register file for the 2-wide RV32 pipeline. It sits directly downstream of the EX→WB pipeline register and commits both writeback slots every cycle. It serves four decode-stage source operands, with write-through bypass so a value in writeback is visible to a same-cycle read. It also keeps a retired-write counter for performance monitoring.

## Interface
- XLEN, 32, data width
- NREAD, 4, number of read ports (2 per issue slot)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- wb_rd0  input  5  slot-0 destination from EX→WB register; 0 = no write
- wb_rd1  input  5  slot-1 destination; 0 = no write
- wb_res0  input  XLEN  slot-0 result
- wb_res1  input  XLEN  slot-1 result
- rs_addr  input  NREAD×5  read addresses; port k uses bits [5k+4:5k]
- rs_data  output  NREAD×XLEN  read data; port k uses bits [XLEN·k+XLEN-1:XLEN·k]
- wb_count  output  32  number of architectural register writes performed

## Operation
- Storage holds x1..x31 (31×XLEN flops). x0 is not stored and always reads 0.
- The write enable for slot s is (wb_rds != 0). There is no separate valid signal; rd = 0 encodes a bubble or a non-writing instruction.
- Writes:
  - On each rising clk with reset_n high, enabled slots write their result to reg[wb_rds].
  - If wb_rd0 == wb_rd1 != 0, only slot 1 writes, because it is the younger instruction in program order.
- Reads are combinational, with this priority for port k and address a:
  - a == 0 → 0
  - a == wb_rd1 → wb_res1
  - a == wb_rd0 → wb_res0
  - otherwise reg[a]
- While reset_n is low, every rs_data port reads 0 and the bypass is disabled.
- wb_count increments each clock by the number of registers actually written: 0, 1 or 2. A same-rd collision counts as 1. The counter wraps modulo 2^32 with no saturation.
- No stall input. The upstream register holds its outputs when stalled, so re-committing the same value is idempotent. wb_count therefore also counts repeats during a stall; this is documented behaviour, not a bug.

## Timing
- Read latency: 0 cycles, purely combinational from rs_addr, wb_rd*, wb_res*.
- Write latency: the value is in the array after the rising edge and readable from the array the next cycle. It is visible the same cycle through the bypass.
- Reset values:
  - all reg[1..31] = 0
  - wb_count = 0
  - rs_data = 0 while reset is asserted
- Reset asserted mid-cycle clears the array and counter immediately, without waiting for a clock edge. The first write is accepted on the first rising edge after reset_n goes high.
- Simultaneous events:
  - Both slots write different registers → both commit, count += 2.
  - Both slots write the same register → slot 1 commits, count += 1.
  - Read of x0 while a slot targets x0 → 0, since a write to x0 is not a write.

## Structure
- Shared package riscv_pkg holds XLEN, REG_ADDR_W = 5, NUM_ARCH_REGS = 32, and the typedef reg_addr_t.
- Sub-module rf_read_port implements one address-compare, bypass and x0 mux. It is instantiated NREAD times in a generate loop.
- The write decode and the counter stay in the top module.

## Test plan
- **Reset.** Assert reset_n low mid-run, after filling the registers with 0xFFFF_FFFF. Required: all four rs_data read 0 immediately; after release, reads of x1..x31 return 0 and wb_count = 0.
- **Basic write and read.** Apply wb_rd0 = 5, wb_res0 = 0x1234_5678, wb_rd1 = 0 for one cycle, then idle. Required: reading x5 next cycle returns 0x1234_5678; wb_count = 1.
- **Same-cycle bypass.** Apply wb_rd1 = 7, wb_res1 = 0xDEAD_BEEF with rs_addr port 2 = 7 in the same cycle. Required: rs_data[2] = 0xDEAD_BEEF before the edge.
- **Slot collision.** Apply wb_rd0 = wb_rd1 = 10, wb_res0 = 0xA, wb_res1 = 0xB. Required: the same-cycle read returns 0xB; after the edge x10 = 0xB; wb_count increases by 1.
- **x0 immunity.** Apply wb_rd0 = 0, wb_res0 = 0x55 and wb_rd1 = 0, wb_res1 = 0x66, with all ports reading x0. Required: all reads return 0 and wb_count is unchanged.
- **Counter wrap and dual commit.** Preload wb_count to 0xFFFF_FFFF by forcing it, then write x3 and x4 in one cycle. Required: wb_count = 0x0000_0001, and both registers hold their values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 architectural constants and types for the integer register file.
package riscv_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback-commit and operand-read bundle between the pipeline and wb_regfile.
interface wb_regfile_if #(
  parameter int NREAD = 4
);
  import riscv_pkg::*;

  reg_addr_t                 wb_rd0;
  reg_addr_t                 wb_rd1;
  logic [XLEN-1:0]           wb_res0;
  logic [XLEN-1:0]           wb_res1;
  logic [NREAD*REG_ADDR_W-1:0] rs_addr;
  logic [NREAD*XLEN-1:0]     rs_data;
  logic [31:0]               wb_count;

  // Pipeline side: drives writeback slots and read addresses.
  modport master (
    output wb_rd0, wb_rd1, wb_res0, wb_res1, rs_addr,
    input  rs_data, wb_count
  );

  // Register file side.
  modport slave (
    input  wb_rd0, wb_rd1, wb_res0, wb_res1, rs_addr,
    output rs_data, wb_count
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: x0 forcing, writeback bypass and array select.
module rf_read_port
  import riscv_pkg::*;
(
  input  logic            i_en,
  input  reg_addr_t       i_addr,
  input  reg_addr_t       i_rd0,
  input  reg_addr_t       i_rd1,
  input  logic [XLEN-1:0] i_res0,
  input  logic [XLEN-1:0] i_res1,
  input  logic [XLEN-1:0] i_arr,
  output logic [XLEN-1:0] o_data
);

  // Slot 1 is younger than slot 0, so its result wins when both target the address.
  always_comb begin
    o_data = '0;
    if (i_en && (i_addr != '0)) begin
      if (i_addr == i_rd1) begin
        o_data = i_res1;
      end else if (i_addr == i_rd0) begin
        o_data = i_res0;
      end else begin
        o_data = i_arr;
      end
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Dual-write, multi-read RV32 integer register file with write-through bypass
// and a retired-write counter.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int NREAD = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  wb_regfile_if.slave  bus
);

  logic [XLEN-1:0] r_regs [1:NUM_ARCH_REGS-1];
  logic [31:0]     r_wb_count;

  logic            w_we0;
  logic            w_we1;
  logic [31:0]     w_inc;
  logic [XLEN-1:0] w_port_data [NREAD];

  // rd == 0 encodes a bubble; on a same-rd collision only the younger slot 1 writes.
  assign w_we1 = (bus.wb_rd1 != '0);
  assign w_we0 = (bus.wb_rd0 != '0) && (bus.wb_rd0 != bus.wb_rd1);
  assign w_inc = 32'(w_we0) + 32'(w_we1);

  // Commit both writeback slots into the array; reset clears it asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NUM_ARCH_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_ARCH_REGS; i++) begin
        if (w_we1 && (bus.wb_rd1 == reg_addr_t'(i))) begin
          r_regs[i] <= bus.wb_res1;
        end else if (w_we0 && (bus.wb_rd0 == reg_addr_t'(i))) begin
          r_regs[i] <= bus.wb_res0;
        end
      end
    end
  end

  // Count architectural writes actually performed; wraps modulo 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_count <= '0;
    end else begin
      r_wb_count <= r_wb_count + w_inc;
    end
  end

  assign bus.wb_count = r_wb_count;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    reg_addr_t       w_addr;
    logic [XLEN-1:0] w_arr;

    assign w_addr = bus.rs_addr[REG_ADDR_W*k +: REG_ADDR_W];

    // x0 has no storage, so only index the array for a non-zero address.
    always_comb begin
      w_arr = '0;
      if (w_addr != '0) begin
        w_arr = r_regs[w_addr];
      end
    end

    rf_read_port u_port (
      .i_en   (reset_n),
      .i_addr (w_addr),
      .i_rd0  (bus.wb_rd0),
      .i_rd1  (bus.wb_rd1),
      .i_res0 (bus.wb_res0),
      .i_res1 (bus.wb_res1),
      .i_arr  (w_arr),
      .o_data (w_port_data[k])
    );
  end

  // Pack the per-port results onto the flat read-data bus.
  always_comb begin
    bus.rs_data = '0;
    for (int k = 0; k < NREAD; k++) begin
      bus.rs_data[XLEN*k +: XLEN] = w_port_data[k];
    end
  end

endmodule
